// File: rtl/whac_a_mole_multi_if.sv
// Game-side bus of whac_a_mole_multi: spawn/strike inputs in, mole/score status out.
// The controller takes the slave modport; the stimulus side takes master.
interface whac_a_mole_multi_if #(
    parameter int POS_W     = 4,
    parameter int NUM_MOLES = 2,
    parameter int DIGITS    = 2
);
    logic [POS_W-1:0]           random;
    logic [POS_W-1:0]           mallet_position;
    logic                       PRESS_VALID;
    logic                       timesup;
    logic [NUM_MOLES-1:0]       mole_valid;
    logic [NUM_MOLES*POS_W-1:0] mole_position;
    logic [4*DIGITS-1:0]        score_bcd;
    logic [7:0]                 miss_count;
    logic                       hit_pulse;

    modport master (
        output random, mallet_position, PRESS_VALID, timesup,
        input  mole_valid, mole_position, score_bcd, miss_count, hit_pulse
    );
    modport slave (
        input  random, mallet_position, PRESS_VALID, timesup,
        output mole_valid, mole_position, score_bcd, miss_count, hit_pulse
    );
endinterface

// File: rtl/whac_a_mole_multi.sv
// Multi-slot whac-a-mole controller: NUM_MOLES IDLE->UP->DOWN slots, BCD score, miss counter.
// Optional macro WHAC_MISS_PENALTY_EN: each timed-out mole also takes one point off the score.
module whac_a_mole_multi #(
    parameter int NUM_HOLES = 16,
    parameter int POS_W     = 4,
    parameter int NUM_MOLES = 2,
    parameter int UP_TICKS  = 1000000,
    parameter int GAP_TICKS = 500000,
    parameter int CNT_W     = 20,
    parameter int DIGITS    = 2
) (
    input  logic               clk_1us,
    input  logic               reset,
    whac_a_mole_multi_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} slot_st_e;

    localparam int               TW       = $clog2(NUM_MOLES + 1);
    localparam logic [CNT_W-1:0] UP_LAST  = CNT_W'(UP_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
    localparam logic [POS_W:0]   HOLES    = (POS_W + 1)'(NUM_HOLES);

    slot_st_e                            st [NUM_MOLES];
    logic [NUM_MOLES-1:0][CNT_W-1:0]     cnt;
    logic [NUM_MOLES-1:0][POS_W-1:0]     pos;
    logic [NUM_MOLES-1:0]                vld;
    logic [NUM_MOLES-1:0]                spawn, hit, tmo;
    logic                                cand_ok, seen_idle;
    logic [TW-1:0]                       nto;
    logic [4*DIGITS-1:0]                 score_q, score_nxt;
    logic [7:0]                          miss_q, miss_nxt;
    logic [8:0]                          miss_sum;
    logic                                hit_q;

    // Increment saturates at all-nines: a carry out of the top digit keeps the old value.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (c) begin
                if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
                else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return c ? v : r;
    endfunction

`ifdef WHAC_MISS_PENALTY_EN
    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                b;
        r = v;
        b = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (b) begin
                if (r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'd9;
                else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return b ? v : r;
    endfunction
    logic [TW-1:0] dec_n;
`endif

    always_comb begin
        spawn     = '0;
        hit       = '0;
        tmo       = '0;
        nto       = '0;
        seen_idle = 1'b0;
        cand_ok   = !bus.timesup && ({1'b0, bus.random} < HOLES);
        for (int i = 0; i < NUM_MOLES; i++)
            if (st[i] == S_UP && pos[i] == bus.random) cand_ok = 1'b0;
        // Only the lowest-index idle slot may take the candidate.
        for (int i = 0; i < NUM_MOLES; i++) begin
            if (st[i] == S_IDLE && !seen_idle) begin
                spawn[i]  = cand_ok;
                seen_idle = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MOLES; i++) begin
            hit[i] = st[i] == S_UP && bus.PRESS_VALID && !bus.timesup
                     && bus.mallet_position == pos[i];
            tmo[i] = st[i] == S_UP && !bus.timesup && !hit[i] && cnt[i] == UP_LAST;
            nto    = nto + TW'(tmo[i]);
        end
        miss_sum  = {1'b0, miss_q} + 9'(nto);
        miss_nxt  = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        score_nxt = score_q;
`ifdef WHAC_MISS_PENALTY_EN
        // A hit cancels one timeout outright so saturation/floor cannot bias the net result.
        dec_n = nto;
        if (|hit) begin
            if (nto != '0) dec_n = nto - TW'(1);
            else           score_nxt = bcd_inc(score_q);
        end
        for (int i = 0; i < NUM_MOLES; i++)
            if (TW'(i) < dec_n) score_nxt = bcd_dec(score_nxt);
`else
        if (|hit) score_nxt = bcd_inc(score_q);
`endif
    end

    always_ff @(posedge clk_1us) begin
        if (reset) begin
            for (int i = 0; i < NUM_MOLES; i++) begin
                st[i]  <= S_IDLE;
                cnt[i] <= '0;
                pos[i] <= '0;
            end
            vld     <= '0;
            score_q <= '0;
            miss_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MOLES; i++) begin
                case (st[i])
                    S_IDLE: if (spawn[i]) begin
                        st[i]  <= S_UP;
                        pos[i] <= bus.random;
                        cnt[i] <= '0;
                        vld[i] <= 1'b1;
                    end
                    S_UP: if (bus.timesup || hit[i] || tmo[i]) begin
                        st[i]  <= S_DOWN;
                        cnt[i] <= '0;
                        vld[i] <= 1'b0;
                    end else cnt[i] <= cnt[i] + CNT_W'(1);
                    S_DOWN: if (cnt[i] == GAP_LAST) st[i] <= S_IDLE;
                            else cnt[i] <= cnt[i] + CNT_W'(1);
                    default: st[i] <= S_IDLE;
                endcase
            end
            score_q <= score_nxt;
            miss_q  <= miss_nxt;
            hit_q   <= |hit;
        end
    end

    assign bus.mole_valid    = vld;
    assign bus.mole_position = pos;
    assign bus.score_bcd     = score_q;
    assign bus.miss_count    = miss_q;
    assign bus.hit_pulse     = hit_q;
endmodule

// File: tb/tb_whac_a_mole_multi.sv
// Bench for whac_a_mole_multi: timestamp-based game model checked every cycle plus directed steps.
module tb_whac_a_mole_multi;
    localparam int NH = 16, PW = 4, NM = 2, UT = 10, GT = 5, CW = 8, DG = 2;

    logic clk_1us = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_1us = ~clk_1us;

    whac_a_mole_multi_if #(.POS_W(PW), .NUM_MOLES(NM), .DIGITS(DG)) bus ();
    whac_a_mole_multi_if #(.POS_W(PW), .NUM_MOLES(NM), .DIGITS(DG)) bus4 ();

    whac_a_mole_multi #(.NUM_HOLES(NH), .POS_W(PW), .NUM_MOLES(NM), .UP_TICKS(UT),
                        .GAP_TICKS(GT), .CNT_W(CW), .DIGITS(DG))
        dut (.clk_1us(clk_1us), .reset(reset), .bus(bus));
    whac_a_mole_multi #(.NUM_HOLES(4), .POS_W(PW), .NUM_MOLES(NM), .UP_TICKS(UT),
                        .GAP_TICKS(GT), .CNT_W(CW), .DIGITS(DG))
        dut4 (.clk_1us(clk_1us), .reset(reset), .bus(bus4));

    int errs = 0, checks = 0;
    bit rand_in = 1'b0;

    // Model: each slot is either up (with a timeout edge) or down until a free-from edge.
    int edge_n = 0;
    bit m_up [NM];
    int m_pos [NM], m_dl [NM], m_free [NM];
    int m_score = 0, m_miss = 0, m_hitp = 0, tmo_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        checks++;
        errs++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    function automatic logic [7:0] to_bcd(input int s);
        return 8'((s / 10) * 16 + s % 10);
    endfunction

    task automatic model_step();
        bit was_up [NM];
        bit cand, hit;
        int sp, nto;
        edge_n++;
        if (reset) begin
            for (int i = 0; i < NM; i++) begin
                m_up[i] = 1'b0; m_pos[i] = 0; m_free[i] = edge_n + 1;
            end
            m_score = 0; m_miss = 0; m_hitp = 0;
            return;
        end
        cand = !bus.timesup && int'(bus.random) < NH;
        for (int i = 0; i < NM; i++) begin
            was_up[i] = m_up[i];
            if (m_up[i] && m_pos[i] == int'(bus.random)) cand = 1'b0;
        end
        sp = -1;
        for (int i = 0; i < NM; i++)
            if (sp < 0 && !m_up[i] && edge_n >= m_free[i]) sp = i;
        nto = 0;
        hit = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (was_up[i]) begin
                if (bus.timesup) begin
                    m_up[i] = 1'b0; m_free[i] = edge_n + GT + 1;
                end else if (bus.PRESS_VALID && int'(bus.mallet_position) == m_pos[i]) begin
                    hit = 1'b1; m_up[i] = 1'b0; m_free[i] = edge_n + GT + 1;
                end else if (edge_n == m_dl[i]) begin
                    nto++; m_up[i] = 1'b0; m_free[i] = edge_n + GT + 1;
                end
            end
        end
        if (cand && sp >= 0) begin
            m_up[sp] = 1'b1; m_pos[sp] = int'(bus.random); m_dl[sp] = edge_n + UT;
        end
        tmo_total += nto;
        m_miss = (m_miss + nto > 255) ? 255 : m_miss + nto;
`ifdef WHAC_MISS_PENALTY_EN
        m_score = m_score + int'(hit) - nto;
        if (m_score < 0) m_score = 0;
        if (m_score > 99) m_score = 99;
`else
        if (hit && m_score < 99) m_score++;
`endif
        m_hitp = int'(hit);
    endtask

    always @(posedge clk_1us) model_step();

    always @(negedge clk_1us) begin
        for (int i = 0; i < NM; i++) begin
            chk($sformatf("valid%0d", i), 32'(bus.mole_valid[i]), 32'(m_up[i]));
            if (m_up[i]) chk($sformatf("pos%0d", i), 32'(bus.mole_position[i*PW +: PW]), 32'(m_pos[i]));
        end
        chk("score", 32'(bus.score_bcd), 32'(to_bcd(m_score)));
        chk("miss", 32'(bus.miss_count), 32'(m_miss));
        chk("hit_pulse", 32'(bus.hit_pulse), 32'(m_hitp));
    end

    task automatic tick();
        @(negedge clk_1us);
        if (rand_in) bus.random = PW'($urandom_range(0, 15));
    endtask

    task automatic do_hit();
        int k = 0;
        while (!(m_up[0] || m_up[1]) && k < 40) begin tick(); k++; end
        if (!(m_up[0] || m_up[1])) expire("hit_wait");
        else begin
            bus.mallet_position = PW'(m_up[0] ? m_pos[0] : m_pos[1]);
            bus.PRESS_VALID = 1'b1;
            tick();
            bus.PRESS_VALID = 1'b0;
        end
    endtask

    initial begin
        int k, sc0, ms0;
        bus.random = '0; bus.mallet_position = '0; bus.PRESS_VALID = 1'b0; bus.timesup = 1'b0;
        bus4.random = 4'd5; bus4.mallet_position = '0; bus4.PRESS_VALID = 1'b0; bus4.timesup = 1'b0;
        reset = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(bus.mole_valid), 0);
        chk("rst_pos", 32'(bus.mole_position), 0);
        chk("rst_score", 32'(bus.score_bcd), 0);
        chk("rst_miss", 32'(bus.miss_count), 0);
        chk("rst_pulse", 32'(bus.hit_pulse), 0);
        reset = 1'b0;

        // Spawn, collision rejection, hit.
        bus.random = 4'd5;
        tick();
        chk("spawn0", 32'(bus.mole_valid), 32'h1);
        chk("spawn0_pos", 32'(bus.mole_position[PW-1:0]), 5);
        tick(); tick();
        chk("collide", 32'(bus.mole_valid[1]), 0);
        bus.mallet_position = 4'd5; bus.PRESS_VALID = 1'b1;
        tick();
        bus.PRESS_VALID = 1'b0;
        chk("hit_valid", 32'(bus.mole_valid[0]), 0);
        chk("hit_score", 32'(bus.score_bcd), 32'h01);
        chk("hit_pulse1", 32'(bus.hit_pulse), 1);
        bus.random = 4'd15;
        tick();
        chk("hit_pulse0", 32'(bus.hit_pulse), 0);
        chk("spawn15", 32'(bus.mole_valid), 32'h2);
        chk("spawn15_pos", 32'(bus.mole_position[2*PW-1:PW]), 15);
        repeat (6) tick();
        chk("collide15", 32'(bus.mole_valid[0]), 0);
        bus.random = 4'd3;
        tick();
        chk("both_up", 32'(bus.mole_valid), 32'h3);

        // timesup drops both moles, ignores presses, blocks spawns.
        ms0 = m_miss; sc0 = m_score;
        bus.timesup = 1'b1;
        tick();
        chk("ts_valid", 32'(bus.mole_valid), 0);
        chk("ts_miss", 32'(bus.miss_count), 32'(ms0));
        bus.mallet_position = 4'd3; bus.PRESS_VALID = 1'b1; rand_in = 1'b1;
        repeat (12) begin
            tick();
            chk("ts_nospawn", 32'(bus.mole_valid), 0);
            chk("ts_score", 32'(bus.score_bcd), 32'(to_bcd(sc0)));
        end
        bus.PRESS_VALID = 1'b0; bus.timesup = 1'b0;
        k = 0;
        while (!(m_up[0] || m_up[1]) && k < 40) begin tick(); k++; end
        if (k >= 40) expire("ts_resume");
        else chk("ts_resume", 32'(bus.mole_valid != 0), 1);

        // Timeouts until miss_count saturates.
        k = 0;
        while (tmo_total < 300 && k < 6000) begin tick(); k++; end
        if (tmo_total < 300) expire("miss_sat_wait");
        chk("miss_sat", 32'(bus.miss_count), 255);

        // Score carry and saturation.
        k = 0;
        while (m_score < 9 && k < 200) begin do_hit(); k++; end
        do_hit();
        if (m_score == 10) chk("carry", 32'(bus.score_bcd), 32'h10);
        k = 0;
        while (m_score < 99 && k < 600) begin do_hit(); k++; end
        if (m_score < 99) expire("sat_wait");
        do_hit();
        if (m_score == 99) begin
            chk("sat_score", 32'(bus.score_bcd), 32'h99);
            chk("sat_pulse", 32'(bus.hit_pulse), 1);
        end

        // Mid-game reset.
        reset = 1'b1; tick(); reset = 1'b0;
        k = 0;
        while (m_score < 37 && k < 300) begin do_hit(); k++; end
        k = 0;
        while (m_miss < 4 && k < 300) begin tick(); k++; end
        k = 0;
        while (!(m_up[0] && m_up[1]) && k < 200) begin tick(); k++; end
        if (!(m_up[0] && m_up[1])) expire("both_up_wait");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_valid", 32'(bus.mole_valid), 0);
        chk("mrst_pos", 32'(bus.mole_position), 0);
        chk("mrst_score", 32'(bus.score_bcd), 0);
        chk("mrst_miss", 32'(bus.miss_count), 0);
        k = 0;
        while (!(m_up[0] || m_up[1]) && k < 40) begin tick(); k++; end
        if (k >= 40) expire("mrst_resume");
        else chk("mrst_resume", 32'(bus.mole_valid != 0), 1);

        // Randomized play.
        repeat (1500) begin
            bus.PRESS_VALID = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1 && (m_up[0] || m_up[1]))
                bus.mallet_position = PW'(m_up[0] ? m_pos[0] : m_pos[1]);
            else
                bus.mallet_position = PW'($urandom_range(0, 15));
            bus.timesup = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; bus.timesup = 1'b0; bus.PRESS_VALID = 1'b0;
        tick();

        // Four-hole instance never accepts hole 5.
        chk("holes4_reject", 32'(bus4.mole_valid), 0);
        bus4.random = 4'd3;
        tick();
        chk("holes4_spawn", 32'(bus4.mole_valid), 32'h1);
        chk("holes4_pos", 32'(bus4.mole_position[PW-1:0]), 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/whac_a_mole_multi.md
Name: whac_a_mole_multi

Overview:
- Parametrised successor of the single-mole game controller.
- Runs NUM_MOLES independent mole slots over NUM_HOLES holes, with configurable up/gap times and a DIGITS-wide BCD score.
- Adds a saturating miss counter and a one-cycle hit strobe.
- Sits between the random generator / keypad decoder and the mole decoder / 7-segment score drivers.

Parameters:
- NUM_HOLES, 16, number of valid hole positions (2..2**POS_W).
- POS_W, 4, width of a hole position.
- NUM_MOLES, 2, simultaneous mole slots (1..4).
- UP_TICKS, 1000000, clk_1us cycles a mole stays up (1 s).
- GAP_TICKS, 500000, clk_1us cycles a slot stays down after a hit or timeout (0.5 s).
- CNT_W, 20, slot counter width; must hold max(UP_TICKS, GAP_TICKS)-1.
- DIGITS, 2, BCD score digits.

Ports:
- clk_1us  in  1  1 us system clock.
- reset  in  1  synchronous, active-high reset.
- random  in  POS_W  candidate hole for the next spawn.
- mallet_position  in  POS_W  hole currently struck.
- PRESS_VALID  in  1  strike qualifier, sampled every cycle.
- timesup  in  1  game over; freezes play.
- mole_valid  out  NUM_MOLES  slot i has a mole up.
- mole_position  out  NUM_MOLES*POS_W  slot i position at bits [i*POS_W +: POS_W]; valid only when mole_valid[i].
- score_bcd  out  4*DIGITS  score; digit 0 is bits [3:0].
- miss_count  out  8  moles that timed out unhit, saturating.
- hit_pulse  out  1  high for one cycle after each scored hit.

Behaviour:
- Single clock, all state registered on posedge clk_1us. Reset is synchronous and active-high.
- Reset, including mid-game, clears everything next edge: all slots IDLE, counters 0, mole_valid=0, mole_position=0, score_bcd=0, miss_count=0, hit_pulse=0.
- Per-slot FSM IDLE -> UP -> DOWN -> IDLE, each slot with its own CNT_W counter.
- IDLE -> UP (spawn) requires all of:
  - !timesup;
  - the slot is the lowest-index IDLE slot;
  - random < NUM_HOLES;
  - random not equal to the position of any slot currently UP.
  - On spawn: position <= random, counter <= 0, mole_valid high from the next cycle.
  - At most one spawn per cycle. A rejected candidate (out of range or collision) retries next cycle with the new random.
- UP, hit: PRESS_VALID && !timesup && mallet_position == position.
  - Next edge: slot -> DOWN, counter <= 0, mole_valid <= 0, score +1, hit_pulse <= 1.
  - Positions of UP slots are unique, so at most one hit per cycle.
- UP, timeout: no hit and counter == UP_TICKS-1.
  - Next edge: slot -> DOWN, counter <= 0, miss_count +1 (saturates at 255).
  - A hit on the same cycle as the timeout takes priority and counts as a hit.
- UP otherwise: counter +1.
- DOWN: counter == GAP_TICKS-1 -> IDLE, else counter +1. A slot can respawn no earlier than the cycle after it returns to IDLE.
- timesup high:
  - no spawns, no hits;
  - every UP slot goes DOWN next edge with no miss counted;
  - DOWN slots finish their gap normally;
  - score and miss_count hold.
  - Deasserting timesup resumes spawning.
- Score arithmetic:
  - BCD increment with per-digit carry (digit 9 -> 0, carry into the next digit).
  - At all-nines (99 for DIGITS=2) the score saturates and does not wrap.
  - Every digit is always in 0..9.
- hit_pulse is 0 on every cycle not immediately following a hit.
- Several timeouts on the same cycle each add 1 to miss_count, clamped at 255.

Optional Feature:
- Macro: WHAC_MISS_PENALTY_EN.
- Defined:
  - Each timed-out mole also decrements the score by 1, BCD borrow, floored at 0.
  - Hit and timeout on the same cycle (different slots) net to zero change.
  - Multiple timeouts subtract each, with the floor applied.
- Undefined: the score only increments; timeouts affect miss_count only.

Test Plan (NUM_HOLES=16, NUM_MOLES=2, UP_TICKS=10, GAP_TICKS=5, DIGITS=2):
- Reset mid-game: score 37, miss 4, both slots UP; pulse reset for 1 cycle -> next edge all outputs 0, slots IDLE; spawning resumes after reset drops.
- Hit: random=5 spawns slot0; 3 cycles later PRESS_VALID=1, mallet=5 -> next edge mole_valid[0]=0, score 00->01, hit_pulse=1 for exactly 1 cycle; slot0 IDLE 5 cycles later.
- Spawn rejection: random held at 5 while slot0 is UP at 5 -> slot1 never spawns; random=15 -> slot1 spawns at 15; random=5 with NUM_HOLES=4 -> no spawn.
- Timeout: no presses; slot UP 10 cycles -> DOWN, miss_count +1. Force 300 timeouts -> miss_count stays 255. With WHAC_MISS_PENALTY_EN, score 10 -> 09 on a timeout and floors at 00.
- Score carry/saturation: hits from 08 -> 09 -> 10 (digit carry); from 99 a further hit keeps 99 and hit_pulse still fires.
- timesup: two slots UP, assert timesup -> both mole_valid low next edge, miss_count unchanged; presses on old positions ignored; no spawns until timesup=0.
